// File: rtl/spi_pixel_frame_ctrl.sv
// SPI frame parser: turns one command per SSEL-low frame into pixel-buffer writes, clears and render pulses.
// Optional brightness register and scaling enabled by SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN.
module spi_pixel_frame_ctrl #(
  parameter int NUM_PIXELS = 64,
  parameter int ADDR_W     = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              frame_active_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ready_i,
  input  logic              render_busy_i,
  output logic              pix_we_o,
  output logic [ADDR_W-1:0] pix_addr_o,
  output logic [23:0]       pix_data_o,
  output logic              render_o,
  output logic              busy_o,
  output logic              err_o
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_COUNT = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_CLEAR = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;
`ifdef SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN
  localparam logic [2:0] S_BRIGHT = 3'd7;
`endif
  localparam logic [8:0]        NP   = 9'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);

  logic [2:0]        state, st_n;
  logic              frame_q, pending, pend_n, pend_set, fire;
  logic [ADDR_W-1:0] addr, addr_n, paddr_n;
  logic [8:0]        cnt, cnt_n, clr_cnt, clr_n;
  logic [1:0]        idx, idx_n;
  logic [7:0]        b0, b0_n, b1, b1_n;
  logic              written, wr_n, we_n, busy_n, err_n;
  logic [23:0]       pdata_n;
  logic              byte_v, rise, fall;

`ifdef SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN
  logic [7:0] bright, bright_n;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(c) * 16'({1'b0, b} + 9'd1);
    return p[15:8];
  endfunction
`endif

  // A byte arriving on the same edge SSEL drops still belongs to the frame.
  assign byte_v = rx_ready_i & (frame_active_i | frame_q);
  assign rise   = frame_active_i & ~frame_q;
  assign fall   = ~frame_active_i & frame_q;

  always_comb begin
    st_n = state; addr_n = addr; cnt_n = cnt; idx_n = idx; b0_n = b0; b1_n = b1;
    wr_n = written; clr_n = clr_cnt; pend_set = 1'b0; err_n = 1'b0;
    we_n = 1'b0; paddr_n = pix_addr_o; pdata_n = pix_data_o; busy_n = 1'b0;
`ifdef SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN
    bright_n = bright;
`endif
    if (state == S_CLEAR) begin
      if (clr_cnt == NP) begin
        st_n = frame_active_i ? S_DRAIN : S_IDLE;
      end else begin
        we_n = 1'b1; paddr_n = ADDR_W'(clr_cnt); pdata_n = '0; busy_n = 1'b1;
        clr_n = clr_cnt + 9'd1;
      end
    end else if (rise) begin
      st_n = S_CMD;
    end else begin
      if (byte_v) begin
        case (state)
          S_CMD: begin
            case (rx_data_i)
              8'h01: st_n = S_ADDR;
              8'h02: begin pend_set = 1'b1; st_n = S_DRAIN; end
              8'h03: begin
                // First clear write goes out with the command byte so the sweep is exactly NUM_PIXELS cycles.
                st_n = S_CLEAR; we_n = 1'b1; paddr_n = '0; pdata_n = '0;
                busy_n = 1'b1; clr_n = 9'd1;
              end
`ifdef SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN
              8'h04: st_n = S_BRIGHT;
`endif
              default: begin err_n = 1'b1; st_n = S_DRAIN; end
            endcase
          end
          S_ADDR: begin
            addr_n = ADDR_W'({1'b0, rx_data_i} % NP);
            wr_n = 1'b0; idx_n = 2'd0; st_n = S_COUNT;
          end
          S_COUNT: begin
            cnt_n = (rx_data_i == 8'h00) ? 9'd256 : {1'b0, rx_data_i};
            st_n = S_DATA;
          end
          S_DATA: begin
            case (idx)
              2'd0: begin b0_n = rx_data_i; idx_n = 2'd1; end
              2'd1: begin b1_n = rx_data_i; idx_n = 2'd2; end
              default: begin
                we_n = 1'b1; paddr_n = addr;
`ifdef SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN
                pdata_n = {scale(b0, bright), scale(b1, bright), scale(rx_data_i, bright)};
`else
                pdata_n = {b0, b1, rx_data_i};
`endif
                addr_n = (addr == LAST) ? '0 : addr + 1'b1;
                cnt_n = cnt - 9'd1; idx_n = 2'd0; wr_n = 1'b1;
                if (cnt == 9'd1) st_n = S_DRAIN;
              end
            endcase
          end
`ifdef SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN
          S_BRIGHT: begin bright_n = rx_data_i; st_n = S_DRAIN; end
`endif
          default: ;
        endcase
      end
      // End-of-frame rules act on the state reached after this cycle's byte.
      if (fall) begin
        case (st_n)
          S_ADDR, S_COUNT: begin st_n = S_IDLE; err_n = 1'b1; end
          S_DATA: begin
            st_n = S_IDLE;
            if (!(idx_n == 2'd0 && wr_n)) err_n = 1'b1;
          end
          S_CMD, S_DRAIN: st_n = S_IDLE;
`ifdef SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN
          S_BRIGHT: st_n = S_IDLE;
`endif
          default: ;
        endcase
      end
    end
    fire   = pending & ~render_busy_i & (state != S_CLEAR) & (st_n != S_CLEAR);
    pend_n = (pending & ~fire) | pend_set;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= S_IDLE; frame_q <= 1'b0; pending <= 1'b0; addr <= '0; cnt <= '0;
      idx <= '0; b0 <= '0; b1 <= '0; written <= 1'b0; clr_cnt <= '0;
      pix_we_o <= 1'b0; pix_addr_o <= '0; pix_data_o <= '0;
      render_o <= 1'b0; busy_o <= 1'b0; err_o <= 1'b0;
`ifdef SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN
      bright <= 8'hFF;
`endif
    end else begin
      state <= st_n; frame_q <= frame_active_i; pending <= pend_n; addr <= addr_n;
      cnt <= cnt_n; idx <= idx_n; b0 <= b0_n; b1 <= b1_n; written <= wr_n; clr_cnt <= clr_n;
      pix_we_o <= we_n; pix_addr_o <= paddr_n; pix_data_o <= pdata_n;
      render_o <= fire; busy_o <= busy_n; err_o <= err_n;
`ifdef SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN
      bright <= bright_n;
`endif
    end
  end
endmodule

// File: tb/tb_spi_pixel_frame_ctrl.sv
// Scoreboard bench for spi_pixel_frame_ctrl: expected writes queued at stimulus time, matched against observed writes.
module tb_spi_pixel_frame_ctrl;
  localparam int NP = 64;
  localparam int AW = 8;

  typedef struct packed {
    logic [7:0]  a;
    logic [23:0] d;
    logic [31:0] c;
  } wr_t;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          frame_active_i = 1'b0;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_ready_i = 1'b0;
  logic          render_busy_i = 1'b0;
  logic          pix_we_o, render_o, busy_o, err_o;
  logic [AW-1:0] pix_addr_o;
  logic [23:0]   pix_data_o;

  int vectors = 0, miscompares = 0;
  int cyc = 0, err_cnt = 0, ren_cnt = 0, ren_cyc = 0, ren_busy = 0, busy_cnt = 0, bfall_cyc = 0;
  logic busy_q = 1'b0;
  wr_t exq[$], obsq[$];
  logic [7:0] fb[$];

  spi_pixel_frame_ctrl #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .frame_active_i(frame_active_i),
    .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i), .render_busy_i(render_busy_i),
    .pix_we_o(pix_we_o), .pix_addr_o(pix_addr_o), .pix_data_o(pix_data_o),
    .render_o(render_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (pix_we_o) obsq.push_back({pix_addr_o, pix_data_o, 32'(cyc)});
    if (err_o) err_cnt++;
    if (render_o) begin
      ren_cnt++; ren_cyc = cyc;
      if (busy_o) ren_busy++;
    end
    if (busy_o) busy_cnt++;
    if (busy_q && !busy_o) bfall_cyc = cyc;
    busy_q = busy_o;
  end

  task automatic send_byte(input logic [7:0] b, input bit push, input logic [7:0] a, input logic [23:0] d);
    @(posedge clk_i); #1;
    rx_data_i = b; rx_ready_i = 1'b1;
    if (push) exq.push_back({a, d, 32'(cyc + 1)});
    @(posedge clk_i); #1;
    rx_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
  endtask

  // Drives fb[] as one frame; the WRITE model predicts each pixel's address and data.
  task automatic send_frame(input bit close);
    int a, n, pix;
    bit wr, push;
    logic [23:0] d;
    @(posedge clk_i); #1 frame_active_i = 1'b1;
    repeat (2) @(posedge clk_i);
    wr = (fb.size() >= 3) && (fb[0] == 8'h01);
    a = 0; n = 0; pix = 0;
    if (wr) begin
      a = int'(fb[1]) % NP;
      n = (fb[2] == 8'h00) ? 256 : int'(fb[2]);
    end
    for (int i = 0; i < fb.size(); i++) begin
      push = 1'b0; d = '0;
      if (wr && i >= 3 && ((i - 3) % 3 == 2) && pix < n) begin
        d = {fb[i-2], fb[i-1], fb[i]}; push = 1'b1;
      end
      send_byte(fb[i], push, 8'(a), d);
      if (push) begin a = (a + 1) % NP; pix++; end
    end
    if (close) begin
      @(posedge clk_i); #1 frame_active_i = 1'b0;
      repeat (3) @(posedge clk_i);
    end
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i); #1;
    vectors++; if (pix_we_o !== 1'b0) begin miscompares++; $display("FAIL reset_we got=%b want=0", pix_we_o); end
    vectors++; if (pix_addr_o !== '0) begin miscompares++; $display("FAIL reset_addr got=%h want=0", pix_addr_o); end
    vectors++; if (pix_data_o !== '0) begin miscompares++; $display("FAIL reset_data got=%h want=0", pix_data_o); end
    vectors++; if ({render_o, busy_o, err_o} !== 3'b000) begin miscompares++; $display("FAIL reset_ctl got=%b want=000", {render_o, busy_o, err_o}); end
    @(negedge clk_i); reset_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
  endtask

  task automatic test_write;
    int e0;
    wr_t e, o;
    e0 = err_cnt;
    fb = {8'h01, 8'h05, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame(1'b1);
    vectors++; if (exq.size() != 2) begin miscompares++; $display("FAIL write_model got=%0d want=2", exq.size()); end
    while (exq.size() != 0 && obsq.size() != 0) begin
      e = exq.pop_front(); o = obsq.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL write_px got a=%h d=%h c=%0d want a=%h d=%h c=%0d", o.a, o.d, o.c, e.a, e.d, e.c); end
    end
    vectors++; if (exq.size() != 0 || obsq.size() != 0) begin miscompares++; $display("FAIL write_count got obs_left=%0d want exp_left=%0d", obsq.size(), exq.size()); end
    vectors++; if (err_cnt != e0) begin miscompares++; $display("FAIL write_err got=%0d want=0", err_cnt - e0); end
    exq.delete(); obsq.delete();
  endtask

  task automatic test_wrap;
    wr_t e, o;
    fb = {8'h01, 8'h3F, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h02, 8'h03};
    send_frame(1'b1);
    fb = {8'h01, 8'h45, 8'h01, 8'h0A, 8'h0B, 8'h0C};
    send_frame(1'b1);
    while (exq.size() != 0 && obsq.size() != 0) begin
      e = exq.pop_front(); o = obsq.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL wrap_px got a=%h d=%h c=%0d want a=%h d=%h c=%0d", o.a, o.d, o.c, e.a, e.d, e.c); end
    end
    vectors++; if (exq.size() != 0 || obsq.size() != 0) begin miscompares++; $display("FAIL wrap_count got obs_left=%0d want exp_left=%0d", obsq.size(), exq.size()); end
    exq.delete(); obsq.delete();
  endtask

  task automatic test_render_hold;
    int r0, k;
    render_busy_i = 1'b1;
    r0 = ren_cnt;
    fb = {8'h02};
    send_frame(1'b1);
    send_frame(1'b1);
    repeat (5) @(posedge clk_i);
    vectors++; if (ren_cnt != r0) begin miscompares++; $display("FAIL hold_no_render got=%0d want=0", ren_cnt - r0); end
    @(posedge clk_i); #1 render_busy_i = 1'b0; k = cyc;
    repeat (6) @(posedge clk_i);
    vectors++; if (ren_cnt != r0 + 1) begin miscompares++; $display("FAIL hold_one_render got=%0d want=1", ren_cnt - r0); end
    vectors++; if (ren_cyc != k + 1) begin miscompares++; $display("FAIL hold_render_cyc got=%0d want=%0d", ren_cyc, k + 1); end
  endtask

  task automatic test_clear;
    int r0, b0, e0, k;
    wr_t e, o;
    render_busy_i = 1'b1;
    fb = {8'h02};
    send_frame(1'b1);
    r0 = ren_cnt; b0 = busy_cnt; e0 = err_cnt;
    @(posedge clk_i); #1 frame_active_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(posedge clk_i); #1 rx_data_i = 8'h03; rx_ready_i = 1'b1; k = cyc;
    for (int i = 0; i < NP; i++) exq.push_back({8'(i), 24'h0, 32'(k + 1 + i)});
    @(posedge clk_i); #1 rx_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    send_byte(8'h01, 1'b0, 8'h00, 24'h0);
    @(posedge clk_i); #1 render_busy_i = 1'b0;
    @(posedge clk_i); #1 frame_active_i = 1'b0;
    repeat (80) @(posedge clk_i);
    while (exq.size() != 0 && obsq.size() != 0) begin
      e = exq.pop_front(); o = obsq.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL clear_px got a=%h d=%h c=%0d want a=%h d=%h c=%0d", o.a, o.d, o.c, e.a, e.d, e.c); end
    end
    vectors++; if (exq.size() != 0 || obsq.size() != 0) begin miscompares++; $display("FAIL clear_count got obs_left=%0d want exp_left=%0d", obsq.size(), exq.size()); end
    vectors++; if (busy_cnt - b0 != NP) begin miscompares++; $display("FAIL clear_busy_len got=%0d want=%0d", busy_cnt - b0, NP); end
    vectors++; if (bfall_cyc != k + NP + 1) begin miscompares++; $display("FAIL clear_busy_fall got=%0d want=%0d", bfall_cyc, k + NP + 1); end
    vectors++; if (ren_cnt != r0 + 1) begin miscompares++; $display("FAIL clear_render_cnt got=%0d want=1", ren_cnt - r0); end
    vectors++; if (ren_cyc < bfall_cyc || ren_cyc > bfall_cyc + 1) begin miscompares++; $display("FAIL clear_render_cyc got=%0d want=%0d..%0d", ren_cyc, bfall_cyc, bfall_cyc + 1); end
    vectors++; if (ren_busy != 0) begin miscompares++; $display("FAIL clear_render_busy got=%0d want=0", ren_busy); end
    vectors++; if (err_cnt != e0) begin miscompares++; $display("FAIL clear_err got=%0d want=0", err_cnt - e0); end
    exq.delete(); obsq.delete();
  endtask

  task automatic test_abort;
    int e0, k;
    wr_t e, o;
    e0 = err_cnt;
    fb = {8'h01, 8'h00, 8'h02, 8'h11, 8'h22};
    send_frame(1'b1);
    vectors++; if (obsq.size() != 0) begin miscompares++; $display("FAIL abort_nowrite got=%0d want=0", obsq.size()); end
    vectors++; if (err_cnt != e0 + 1) begin miscompares++; $display("FAIL abort_err got=%0d want=1", err_cnt - e0); end
    e0 = err_cnt;
    fb = {8'hFF};
    send_frame(1'b1);
    vectors++; if (err_cnt != e0 + 1) begin miscompares++; $display("FAIL unknown_ff_err got=%0d want=1", err_cnt - e0); end
`ifndef SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN
    e0 = err_cnt;
    fb = {8'h04};
    send_frame(1'b1);
    vectors++; if (err_cnt != e0 + 1) begin miscompares++; $display("FAIL unknown_04_err got=%0d want=1", err_cnt - e0); end
`endif
    e0 = err_cnt;
    fb = {8'h01, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    send_frame(1'b1);
    // Third byte arrives on the same edge SSEL drops: pixel still written, abort silent.
    @(posedge clk_i); #1 frame_active_i = 1'b1;
    repeat (2) @(posedge clk_i);
    send_byte(8'h01, 1'b0, 8'h00, 24'h0);
    send_byte(8'h10, 1'b0, 8'h00, 24'h0);
    send_byte(8'h02, 1'b0, 8'h00, 24'h0);
    send_byte(8'hAA, 1'b0, 8'h00, 24'h0);
    send_byte(8'hBB, 1'b0, 8'h00, 24'h0);
    @(posedge clk_i); #1 rx_data_i = 8'hCC; rx_ready_i = 1'b1; frame_active_i = 1'b0; k = cyc;
    exq.push_back({8'h10, 24'hAABBCC, 32'(k + 1)});
    @(posedge clk_i); #1 rx_ready_i = 1'b0;
    repeat (4) @(posedge clk_i);
    while (exq.size() != 0 && obsq.size() != 0) begin
      e = exq.pop_front(); o = obsq.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL silent_px got a=%h d=%h c=%0d want a=%h d=%h c=%0d", o.a, o.d, o.c, e.a, e.d, e.c); end
    end
    vectors++; if (exq.size() != 0 || obsq.size() != 0) begin miscompares++; $display("FAIL silent_count got obs_left=%0d want exp_left=%0d", obsq.size(), exq.size()); end
    vectors++; if (err_cnt != e0) begin miscompares++; $display("FAIL silent_err got=%0d want=0", err_cnt - e0); end
    exq.delete(); obsq.delete();
  endtask

  task automatic test_reset_mid;
    wr_t e, o;
    fb = {8'h01, 8'h20, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(1'b0);
    #2 reset_n_i = 1'b0; frame_active_i = 1'b0;
    #1;
    vectors++; if (pix_addr_o !== '0) begin miscompares++; $display("FAIL midrst_addr got=%h want=0", pix_addr_o); end
    vectors++; if (pix_data_o !== '0) begin miscompares++; $display("FAIL midrst_data got=%h want=0", pix_data_o); end
    vectors++; if ({pix_we_o, render_o, busy_o, err_o} !== 4'b0000) begin miscompares++; $display("FAIL midrst_ctl got=%b want=0000", {pix_we_o, render_o, busy_o, err_o}); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); reset_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    fb = {8'h01, 8'h07, 8'h01, 8'h01, 8'h02, 8'h03};
    send_frame(1'b1);
    while (exq.size() != 0 && obsq.size() != 0) begin
      e = exq.pop_front(); o = obsq.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL midrst_px got a=%h d=%h c=%0d want a=%h d=%h c=%0d", o.a, o.d, o.c, e.a, e.d, e.c); end
    end
    vectors++; if (exq.size() != 0 || obsq.size() != 0) begin miscompares++; $display("FAIL midrst_count got obs_left=%0d want exp_left=%0d", obsq.size(), exq.size()); end
    exq.delete(); obsq.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrap();
    test_render_hold();
    test_clear();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_pixel_frame_ctrl.md
Name: spi_pixel_frame_ctrl

Overview:
- Sequences the byte stream from the SPI receive slave into the pixel buffer and triggers the NeoPixel renderer.
- Sits between the SPI receive slave's byte output and the pixel RAM / NeoPixel serializer.
- Parses one command per SPI frame (SSEL low period).
- Commands: pixel writes, buffer clear, and render requests, with a handshake against a busy renderer.

Parameters:
- NUM_PIXELS, 64, number of pixel buffer entries; legal range 1..256.
- ADDR_W, 8, pixel address width; 2**ADDR_W >= NUM_PIXELS.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous active-low reset.
- frame_active_i  in  1  high while SSEL is asserted; already synchronized to clk_i.
- rx_data_i  in  8  received byte; valid when rx_ready_i is high.
- rx_ready_i  in  1  one-cycle pulse per received byte.
- render_busy_i  in  1  renderer is shifting pixels out.
- pix_we_o  out  1  pixel buffer write strobe.
- pix_addr_o  out  ADDR_W  pixel buffer write address.
- pix_data_o  out  24  pixel word: {first, second, third} byte, i.e. {G,R,B}.
- render_o  out  1  one-cycle render start pulse.
- busy_o  out  1  high while CLEAR is sweeping.
- err_o  out  1  one-cycle pulse on unknown command or aborted WRITE.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; render-pending flag 0.
- States: IDLE, CMD, ADDR, COUNT, DATA, CLEAR, DRAIN.
- Frame start:
  - Rising edge of frame_active_i moves to CMD from any state except CLEAR.
  - Bytes seen with frame_active_i low are ignored.
- CMD: the first byte selects the command.
  - 0x01 WRITE -> ADDR.
  - 0x02 SHOW -> set pending, then DRAIN.
  - 0x03 CLEAR -> CLEAR.
  - Any other value -> pulse err_o, then DRAIN.
- ADDR: latch the start address. If the byte is >= NUM_PIXELS, the address wraps modulo NUM_PIXELS. Then go to COUNT.
- COUNT: latch the pixel count; 0 means 256. Then go to DATA.
- DATA:
  - A 2-bit byte index collects three bytes per pixel.
  - Exactly one cycle after the rx_ready_i carrying the third byte: pix_we_o=1 for one cycle, with pix_addr_o = current address and pix_data_o = assembled word.
  - After each write, the address increments; it wraps from NUM_PIXELS-1 to 0 and the count decrements.
  - When the count reaches 0, go to DRAIN.
- DRAIN: ignore bytes until frame_active_i falls, then go to IDLE.
- Frame end (frame_active_i falls) in ADDR, COUNT or DATA:
  - Abort, go to IDLE, pulse err_o.
  - Discard any partial pixel; pixels already written stay written.
  - In DATA with index 0 and at least one pixel already written, the abort is silent (no err_o).
- CLEAR:
  - Writes 24'h0 to addresses 0..NUM_PIXELS-1, one per cycle, with busy_o=1. Takes NUM_PIXELS cycles, starting the cycle after the command byte.
  - Bytes received and frame edges during CLEAR are ignored.
  - On completion: go to DRAIN if frame_active_i is high, else IDLE.
- Render handshake:
  - When pending=1 and render_busy_i=0 and not in CLEAR: render_o=1 for one cycle, pending cleared the same cycle.
  - Repeated SHOW commands while pending collapse into one render.
  - SHOW issued while busy waits; render_o fires on the first cycle render_busy_i is low.
  - render_o is never asserted while busy_o=1.
- Simultaneous rx_ready_i and frame_active_i falling: the byte is processed first, then the abort/end rules apply on the same edge. A pixel completed by that byte is still written.

Optional Feature:
- Macro: SPI_PIXEL_FRAME_CTRL_BRIGHTNESS_EN.
- When defined:
  - Command 0x04 takes one following byte as a brightness register (reset value 8'hFF), then goes to DRAIN.
  - Each channel of pix_data_o = (c*(bright+1))>>8, registered so that write latency remains exactly one cycle.
  - CLEAR data is unaffected (always 0).
- When undefined: 0x04 is an unknown command (err_o pulse, DRAIN), and data passes unscaled.

Test Plan:
- Frame {01,05,02,11,22,33,44,55,66} -> two writes: addr 5 data 24'h112233, then addr 6 data 24'h445566. Each write is one cycle after the respective third byte. No err_o.
- NUM_PIXELS=64, frame {01,3F,02,AA,BB,CC,01,02,03} -> writes at addr 63, then at addr 0 (wrap).
- Frame {03} -> 64 consecutive writes of 0 to addrs 0..63 with busy_o high for 64 cycles. A SHOW frame sent meanwhile causes render_o only after busy_o falls.
- render_busy_i=1, two SHOW frames {02},{02} -> no render_o. Drop render_busy_i -> exactly one render_o pulse, next cycle.
- Frame {01,00,02,11,22} then SSEL rises -> no pix_we_o, err_o one pulse, state IDLE. The next frame {FF} -> err_o pulse.
- Assert reset_n_i low mid-DATA -> outputs 0 immediately. After release, a WRITE frame behaves normally.
